// File: rtl/mips_sim_pkg.sv
// Shared types and defaults for the CPU boot/run controller.
// Holds the controller state encoding and default run parameters.
package mips_sim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RST_HOLD,
        RUN,
        DONE
    } boot_state_t;

    localparam int DEF_MAX_CYCLES = 100;
    localparam int DEF_RST_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sim_cnt.sv
// Generic loadable down-counter; flags the final counted cycle (count == 1).
// Load wins over decrement; decrement saturates at zero.
module sim_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot/run controller: streams an image into imem, holds the CPU in reset, then runs it to halt or budget.
// Writes land one cycle after each load handshake; load_ready is high only while LOAD awaits words.
module cpu_boot_ctrl
    import mips_sim_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int NUM_WORDS  = 256,
    parameter bit LOAD_EN    = 1'b1,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_resetn,
    input  logic              halt,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    // One timer serves both the reset hold and the run budget, so size it for the larger.
    localparam int                TW       = $clog2(max_int(MAX_CYCLES, RST_CYCLES) + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    boot_state_t       state, state_d;
    logic [ADDR_W-1:0] idx, idx_d;
    logic              imem_we_d;
    logic [ADDR_W-1:0] imem_addr_d;
    logic [DATA_W-1:0] imem_wdata_d;
    logic              load_ready_d;
    logic              cpu_resetn_d;
    logic              done_d;
    logic              timeout_d;
    logic [CNT_W-1:0]  cycle_count_d;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_last;
    logic [TW-1:0]     tmr_val;
    logic              handshake;

    assign handshake = load_valid && load_ready;

    sim_cnt #(
        .W (TW)
    ) u_tmr (
        .clk      (clk),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .last     (tmr_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            idx         <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            load_ready  <= 1'b0;
            cpu_resetn  <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            imem_we     <= imem_we_d;
            imem_addr   <= imem_addr_d;
            imem_wdata  <= imem_wdata_d;
            load_ready  <= load_ready_d;
            cpu_resetn  <= cpu_resetn_d;
            done        <= done_d;
            timeout     <= timeout_d;
            cycle_count <= cycle_count_d;
        end
    end

    always_comb begin
        state_d       = state;
        idx_d         = idx;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr;
        imem_wdata_d  = imem_wdata;
        timeout_d     = timeout;
        cycle_count_d = cycle_count;
        tmr_load      = 1'b0;
        tmr_en        = 1'b0;
        tmr_val       = TW'(RST_CYCLES);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    timeout_d     = 1'b0;
                    cycle_count_d = '0;
                    idx_d         = '0;
                    if (LOAD_EN) begin
                        state_d = LOAD;
                    end else begin
                        state_d  = RST_HOLD;
                        tmr_load = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (handshake) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = idx;
                    imem_wdata_d = load_data;
                    idx_d        = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state_d  = RST_HOLD;
                        tmr_load = 1'b1;
                    end
                end
            end
            RST_HOLD: begin
                if (tmr_last) begin
                    state_d  = RUN;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(MAX_CYCLES);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RUN: begin
                cycle_count_d = cycle_count + 1'b1;
                tmr_en        = 1'b1;
                // A halt on the budget's final cycle still counts as a clean finish.
                if (halt) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (tmr_last) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        load_ready_d = (state_d == LOAD);
        cpu_resetn_d = (state_d == RUN);
        done_d       = (state_d == DONE);
    end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Bench for cpu_boot_ctrl: one loading instance and one preloaded instance, checked against
// an expected-write queue and cycle arithmetic derived from the load/hold/run rules.
module tb_cpu_boot_ctrl;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int NW   = 4;
    localparam int MAXC = 100;
    localparam int RST0 = 3;
    localparam int RST1 = 2;
    localparam int CW   = $clog2(MAXC + 1);

    logic          clk        = 1'b0;
    logic          resetn     = 1'b0;
    logic          start      = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data  = '0;
    logic          halt       = 1'b0;
    logic          sel        = 1'b0;

    int errors = 0;
    int checks = 0;

    logic          start0, start1;
    logic          lr0, we0, cr0, done0, to0;
    logic          lr1, we1, cr1, done1, to1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wd0, wd1;
    logic [CW-1:0] cc0, cc1;

    logic          o_lr, o_we, o_cr, o_done, o_to;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wd;
    logic [CW-1:0] o_cc;

    logic [DW-1:0] dir_w [NW] = '{32'h20010005, 32'h20020003, 32'h00221820, 32'h0000000D};

    assign start0 = start && !sel;
    assign start1 = start && sel;
    assign o_lr   = sel ? lr1   : lr0;
    assign o_we   = sel ? we1   : we0;
    assign o_addr = sel ? addr1 : addr0;
    assign o_wd   = sel ? wd1   : wd0;
    assign o_cr   = sel ? cr1   : cr0;
    assign o_done = sel ? done1 : done0;
    assign o_to   = sel ? to1   : to0;
    assign o_cc   = sel ? cc1   : cc0;

    always #5 clk = ~clk;

    cpu_boot_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .LOAD_EN(1'b1),
        .RST_CYCLES(RST0), .MAX_CYCLES(MAXC)
    ) u0 (
        .clk(clk), .resetn(resetn), .start(start0),
        .load_valid(load_valid), .load_data(load_data), .load_ready(lr0),
        .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
        .cpu_resetn(cr0), .halt(halt), .done(done0), .timeout(to0), .cycle_count(cc0)
    );

    cpu_boot_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .LOAD_EN(1'b0),
        .RST_CYCLES(RST1), .MAX_CYCLES(MAXC)
    ) u1 (
        .clk(clk), .resetn(resetn), .start(start1),
        .load_valid(load_valid), .load_data(load_data), .load_ready(lr1),
        .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
        .cpu_resetn(cr1), .halt(halt), .done(done1), .timeout(to1), .cycle_count(cc1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"},      64'(o_we),   64'd0);
        check({tag, "_addr"},    64'(o_addr), 64'd0);
        check({tag, "_wdata"},   64'(o_wd),   64'd0);
        check({tag, "_ready"},   64'(o_lr),   64'd0);
        check({tag, "_cpurstn"}, 64'(o_cr),   64'd0);
        check({tag, "_done"},    64'(o_done), 64'd0);
        check({tag, "_timeout"}, 64'(o_to),   64'd0);
        check({tag, "_count"},   64'(o_cc),   64'd0);
    endtask

    // mode: 0 = directed words every cycle, 1 = valid alternating 1,0,..., 2 = random valid.
    // halt_at: RUN cycle (1-based) carrying halt, 0 = never. stray_at: RUN cycle carrying start.
    task automatic run_test(input int mode, input int halt_at, input int stray_at);
        logic [AW+DW-1:0] exp_q[$];
        logic [AW+DW-1:0] e;
        logic [DW-1:0]    word;
        logic             v;
        bit               le;
        int               rst, n, acc, hs_last, rise, writes, k, exp_cnt, exp_rise;
        bit               exp_to;

        le      = (sel == 1'b0);
        rst     = le ? RST0 : RST1;
        acc     = 0;
        hs_last = 0;
        rise    = -1;
        writes  = 0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cleared_done",    64'(o_done), 64'd0);
        check("cleared_timeout", 64'(o_to),   64'd0);
        check("cleared_count",   64'(o_cc),   64'd0);

        n = 1;
        while (rise < 0 && n < 400) begin
            if (o_we) begin
                writes++;
                if (!le || exp_q.size() == 0) begin
                    check("extra_we", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(o_addr), 64'(e[AW+DW-1:DW]));
                    check("wr_data", 64'(o_wd),   64'(e[DW-1:0]));
                end
            end
            if (o_cr) begin
                rise = n;
            end else begin
                check("load_ready", 64'(o_lr), 64'(le && acc < NW));
                word = (mode == 0 && acc < NW) ? dir_w[acc] : $urandom;
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (n % 2) == 1;
                    default: v = 1'($urandom_range(0, 1));
                endcase
                load_valid = v;
                load_data  = word;
                if (le && v && o_lr && acc < NW) begin
                    exp_q.push_back({AW'(acc), word});
                    acc++;
                    if (acc == NW) hs_last = n;
                end
                @(negedge clk);
                n++;
            end
        end
        load_valid = 1'b0;

        exp_rise = le ? (hs_last + rst + 1) : (rst + 1);
        check("rise_cycle",  64'(rise),   64'(exp_rise));
        check("write_count", 64'(writes), 64'(le ? NW : 0));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        k = 1;
        while (o_cr && k <= MAXC + 5) begin
            check("run_count", 64'(o_cc), 64'(k - 1));
            halt  = (k == halt_at);
            start = (k == stray_at);
            @(negedge clk);
            k++;
        end
        halt  = 1'b0;
        start = 1'b0;

        exp_to  = !(halt_at >= 1 && halt_at <= MAXC);
        exp_cnt = exp_to ? MAXC : halt_at;
        check("run_len",      64'(k - 1),  64'(exp_cnt));
        check("done",         64'(o_done), 64'd1);
        check("timeout",      64'(o_to),   64'(exp_to));
        check("final_count",  64'(o_cc),   64'(exp_cnt));
        check("done_cpurstn", 64'(o_cr),   64'd0);

        repeat (3) begin
            halt = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        halt = 1'b0;
        check("hold_done",    64'(o_done), 64'd1);
        check("hold_timeout", 64'(o_to),   64'(exp_to));
        check("hold_count",   64'(o_cc),   64'(exp_cnt));
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0; check_reset("rst_u0");
        sel = 1'b1; check_reset("rst_u1");
        sel = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        run_test(0, 37, 0);
        run_test(1, 0, 10);
        run_test(2, 100, 0);
        run_test(2, $urandom_range(1, 99), $urandom_range(1, 60));

        sel = 1'b1;
        run_test(2, $urandom_range(1, 100), 20);
        run_test(1, 0, 0);
        sel = 1'b0;

        // Abort in the middle of an image load, during a write beat.
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        load_valid = 1'b1;
        load_data  = $urandom;
        @(negedge clk);
        load_data  = $urandom;
        @(negedge clk);
        load_valid = 1'b0;
        check("mid_load_we", 64'(o_we), 64'd1);
        #1 resetn = 1'b0;
        #1 check_reset("mid_load");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_test(0, 5, 0);

        // Abort in the middle of a run.
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        load_valid = 1'b1;
        for (int i = 0; i < 40 && !o_cr; i++) begin
            load_data = $urandom;
            @(negedge clk);
        end
        load_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_run_active", 64'(o_cr), 64'd1);
        #1 resetn = 1'b0;
        #1 check_reset("mid_run");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_test(2, 50, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
